bus_timing_ctrl: RTL and testbench

BUS_TIMING_CTRL -- requirements
Module: bus_timing_ctrl

---
 rtl/bus_timing_pkg.sv | 25 ++
 rtl/bus_phase_timer.sv | 35 +++
 rtl/bus_timing_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_timing_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timing_pkg.sv
// Shared types and constants for the bus timing controller and its phase timer.
package bus_timing_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_REC,
    DATA,
    DATA_REC
  } busState_e;

  // Level of every active-low strobe (CS, A_D, RD, WR) when the bus is at rest
  localparam logic STROBE_IDLE = 1'b1;
  // The controller releases the bus whenever it is not actively driving it
  localparam logic OE_IDLE = 1'b0;

  // Smallest counter width (at least 1) able to hold maxVal
  function automatic int cntWidth(input int maxVal);
    int w;
    w = 1;
    while ((1 << w) <= maxVal) w++;
    return w;
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable down-counter; last_o is high during the final cycle of the loaded phase.
module bus_phase_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [TW-1:0] loadVal_i,
  output logic          last_o
);

  logic [TW-1:0] count_q, count_d;

  // Load the phase length minus one on entry, then count down and park at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  // Counter register, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == '0);

endmodule

// File: rtl/bus_timing_ctrl.sv
// Multiplexed address/data bus master: burst reads and writes with fixed
// strobe and recovery lengths; every output comes straight from a flop.
module bus_timing_ctrl
  import bus_timing_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int LW       = 4,
  parameter int T_STROBE = 4,
  parameter int T_GAP    = 2,
  parameter int AUTO_INC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic          abort,
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          CS,
  output logic          A_D,
  output logic          RD,
  output logic          WR,
  output logic          wdata_req,
  output logic          rdata_valid,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  localparam int TMAX = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
  localparam int TW   = cntWidth(TMAX);
  localparam logic [TW-1:0] STROBE_LOAD = TW'(T_STROBE - 1);
  localparam logic [TW-1:0] GAP_LOAD    = TW'(T_GAP - 1);

  busState_e     state_q, state_d;
  logic          op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] remain_q, remain_d;
  logic [DW-1:0] wdataLat_q, wdataLat_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] busOut_q, busOut_d;
  logic          oe_q, oe_d;
  logic          cs_q, cs_d, ad_q, ad_d, rd_q, rd_d, wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdataValid_q, rdataValid_d;
  logic          wdataReq_q, wdataReq_d;
  logic          timerLoad;
  logic [TW-1:0] timerVal;
  logic          phaseLast;

  bus_phase_timer #(.TW(TW)) uTimer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (timerLoad),
    .loadVal_i (timerVal),
    .last_o    (phaseLast)
  );

  // Phase sequencing, burst bookkeeping and pulse generation; abort overrides all
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    wdataLat_d   = wdataLat_q;
    rdata_d      = rdata_q;
    rdataValid_d = 1'b0;
    wdataReq_d   = 1'b0;
    done_d       = 1'b0;
    timerLoad    = 1'b0;
    timerVal     = STROBE_LOAD;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          addr_d     = addr;
          remain_d   = (len == '0) ? '0 : len - LW'(1);
          state_d    = ADDR;
          timerLoad  = 1'b1;
          wdataReq_d = op;
        end
      end
      ADDR: begin
        if (phaseLast) begin
          state_d   = ADDR_REC;
          timerLoad = 1'b1;
          timerVal  = GAP_LOAD;
        end
      end
      ADDR_REC: begin
        if (phaseLast) begin
          state_d   = DATA;
          timerLoad = 1'b1;
          if (op_q) begin
            wdataLat_d = wdata;
          end
        end
      end
      DATA: begin
        if (phaseLast) begin
          state_d   = DATA_REC;
          timerLoad = 1'b1;
          timerVal  = GAP_LOAD;
          if (!op_q) begin
            rdata_d      = bus_in;
            rdataValid_d = 1'b1;
          end
        end
      end
      DATA_REC: begin
        if (phaseLast) begin
          if (remain_q != '0) begin
            remain_d   = remain_q - LW'(1);
            state_d    = ADDR;
            timerLoad  = 1'b1;
            wdataReq_d = op_q;
            if (AUTO_INC != 0) begin
              addr_d = addr_q + AW'(1);
            end
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      rdata_d      = rdata_q;
      rdataValid_d = 1'b0;
      wdataReq_d   = 1'b0;
      done_d       = 1'b0;
    end
  end

  // Bus pins for the coming cycle, derived from the state being entered
  always_comb begin
    cs_d     = STROBE_IDLE;
    ad_d     = STROBE_IDLE;
    rd_d     = STROBE_IDLE;
    wr_d     = STROBE_IDLE;
    oe_d     = OE_IDLE;
    busOut_d = busOut_q;
    busy_d   = (state_d != IDLE);
    case (state_d)
      ADDR: begin
        cs_d     = 1'b0;
        ad_d     = 1'b0;
        wr_d     = 1'b0;
        oe_d     = 1'b1;
        busOut_d = addr_d;
      end
      ADDR_REC: oe_d = 1'b1;
      DATA: begin
        cs_d = 1'b0;
        if (op_d) begin
          wr_d     = 1'b0;
          oe_d     = 1'b1;
          busOut_d = wdataLat_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // All state and output flops; reset parks the bus released with strobes high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      addr_q       <= '0;
      remain_q     <= '0;
      wdataLat_q   <= '0;
      rdata_q      <= '0;
      busOut_q     <= '0;
      oe_q         <= OE_IDLE;
      cs_q         <= STROBE_IDLE;
      ad_q         <= STROBE_IDLE;
      rd_q         <= STROBE_IDLE;
      wr_q         <= STROBE_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdataValid_q <= 1'b0;
      wdataReq_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      wdataLat_q   <= wdataLat_d;
      rdata_q      <= rdata_d;
      busOut_q     <= busOut_d;
      oe_q         <= oe_d;
      cs_q         <= cs_d;
      ad_q         <= ad_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdataValid_q <= rdataValid_d;
      wdataReq_q   <= wdataReq_d;
    end
  end

  assign bus_out     = busOut_q;
  assign bus_oe      = oe_q;
  assign CS          = cs_q;
  assign A_D         = ad_q;
  assign RD          = rd_q;
  assign WR          = wr_q;
  assign wdata_req   = wdataReq_q;
  assign rdata_valid = rdataValid_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bus_timing_ctrl.sv
// Self-checking bench for bus_timing_ctrl: a cycle-arithmetic model of the
// burst timing checked every cycle, plus hand-computed literal expectations.
module tb_bus_timing_ctrl;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int LW      = 4;
  localparam int TS      = 4;
  localparam int TG      = 2;
  localparam int AUTOINC = 1;
  localparam int P       = 2 * (TS + TG);

  logic          clk = 1'b0;
  logic          reset;
  logic          start, startB, op, abort;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic [DW-1:0] wdata, busIn;

  logic [DW-1:0] busOut, rdata;
  logic          busOe, cs, aD, rd, wr, wdataReq, rdataValid, done, busy;
  logic [DW-1:0] busOutB, rdataB;
  logic          busOeB, csB, aDB, rdB, wrB, wdataReqB, rdataValidB, doneB, busyB;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chkOn = 1'b0;

  // Model of the one command in flight: first ADDR cycle, transfer count, cut-off
  bit mValid = 1'b0;
  bit mOp = 1'b0;
  int mC0 = 0;
  int mN = 1;
  int mCut = 1 << 30;
  int mAddr = 0;
  int mWdata = 0;
  int rdTab[4];

  bus_timing_ctrl #(
    .DW(DW), .AW(AW), .LW(LW), .T_STROBE(TS), .T_GAP(TG), .AUTO_INC(AUTOINC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
    .addr(addr), .len(len), .wdata(wdata), .bus_in(busIn),
    .bus_out(busOut), .bus_oe(busOe), .CS(cs), .A_D(aD), .RD(rd), .WR(wr),
    .wdata_req(wdataReq), .rdata_valid(rdataValid), .done(done),
    .rdata(rdata), .busy(busy)
  );

  bus_timing_ctrl #(
    .DW(DW), .AW(AW), .LW(LW), .T_STROBE(TS), .T_GAP(TG), .AUTO_INC(0)
  ) dutNoInc (
    .clk(clk), .reset(reset), .start(startB), .op(op), .abort(abort),
    .addr(addr), .len(len), .wdata(wdata), .bus_in(busIn),
    .bus_out(busOutB), .bus_oe(busOeB), .CS(csB), .A_D(aDB), .RD(rdB), .WR(wrB),
    .wdata_req(wdataReqB), .rdata_valid(rdataValidB), .done(doneB),
    .rdata(rdataB), .busy(busyB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-back data: transfer i of the current command sees rdTab[i]
  always_comb begin
    busIn = 8'hEE;
    if (mValid && (cyc >= mC0)) busIn = DW'(rdTab[((cyc - mC0) / P) % 4]);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit isWr, input int a, input int n, input int wd, input bit withB);
    @(negedge clk);
    op     = isWr;
    addr   = AW'(a);
    len    = LW'(n);
    wdata  = DW'(wd);
    start  = 1'b1;
    startB = withB;
    mValid = 1'b1;
    mOp    = isWr;
    mAddr  = a;
    mN     = (n == 0) ? 1 : n;
    mWdata = wd;
    mC0    = cyc + 1;
    mCut   = 1 << 30;
    @(negedge clk);
    start  = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput("doneTimeout", 32'(seen), 32'd1);
  endtask

  // Every-cycle comparison of the DUT against the timing model
  always @(negedge clk) begin
    int o, i, p, curA;
    logic eCS, eAD, eRD, eWR, eOe, eBusy, eDone, eRv, eWreq;
    logic [7:0] eBus, eRdata;
    bit chkBus;
    bit ok;
    if (chkOn) begin
      eCS = 1; eAD = 1; eRD = 1; eWR = 1; eOe = 0;
      eBusy = 0; eDone = 0; eRv = 0; eWreq = 0;
      eBus = 0; eRdata = 0; chkBus = 0;
      if (mValid && (cyc >= mC0) && (cyc < mCut)) begin
        o = cyc - mC0;
        i = o / P;
        p = o % P;
        if (i < mN) begin
          eBusy = 1;
          curA = (AUTOINC != 0) ? ((mAddr + i) % 256) : mAddr;
          if (p < TS) begin
            eCS = 0; eAD = 0; eWR = 0; eOe = 1;
            eBus = 8'(curA); chkBus = 1;
            eWreq = (p == 0) && mOp;
          end else if (p < TS + TG) begin
            eOe = 1; eBus = 8'(curA); chkBus = 1;
          end else if (p < 2 * TS + TG) begin
            eCS = 0;
            if (mOp) begin
              eWR = 0; eOe = 1; eBus = 8'(mWdata); chkBus = 1;
            end else begin
              eRD = 0;
            end
          end else if ((p == 2 * TS + TG) && !mOp) begin
            eRv = 1; eRdata = 8'(rdTab[i % 4]);
          end
        end else if (o == mN * P) begin
          eDone = 1;
        end
      end
      checkOutput("CS", 32'(cs), 32'(eCS));
      checkOutput("A_D", 32'(aD), 32'(eAD));
      checkOutput("RD", 32'(rd), 32'(eRD));
      checkOutput("WR", 32'(wr), 32'(eWR));
      checkOutput("bus_oe", 32'(busOe), 32'(eOe));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("rdata_valid", 32'(rdataValid), 32'(eRv));
      checkOutput("wdata_req", 32'(wdataReq), 32'(eWreq));
      if (chkBus) checkOutput("bus_out", 32'(busOut), 32'(eBus));
      if (eRv) checkOutput("rdata", 32'(rdata), 32'(eRdata));
      ok = !((rd === 1'b0 && wr === 1'b0) || ((rd === 1'b0 || wr === 1'b0) && cs !== 1'b0));
      checkOutput("strobeRule", 32'(ok), 32'd1);
      ok = !((rdB === 1'b0 && wrB === 1'b0) || ((rdB === 1'b0 || wrB === 1'b0) && csB !== 1'b0));
      checkOutput("strobeRuleNoInc", 32'(ok), 32'd1);
      checkOutput("wdataReqNoInc", 32'(wdataReqB), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0, busyCnt, nGot, doneCnt, doneCntB;
    logic [7:0] got[4];
    logic [7:0] lastB;
    reset = 1'b0; start = 1'b0; startB = 1'b0; op = 1'b0; abort = 1'b0;
    addr = '0; len = '0; wdata = '0;
    for (int k = 0; k < 4; k++) rdTab[k] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstCS", 32'(cs), 32'd1);
    checkOutput("rstA_D", 32'(aD), 32'd1);
    checkOutput("rstRD", 32'(rd), 32'd1);
    checkOutput("rstWR", 32'(wr), 32'd1);
    checkOutput("rstOe", 32'(busOe), 32'd0);
    checkOutput("rstBusOut", 32'(busOut), 32'd0);
    checkOutput("rstRdata", 32'(rdata), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstPulses", 32'({done, rdataValid, wdataReq}), 32'd0);
    reset = 1'b1;
    chkOn = 1'b1;

    // Single write 0x5A to 0x25
    applyStimulus(1'b1, 'h25, 1, 'h5A, 1'b0);
    c0 = cyc;
    checkOutput("wrAddrPhase", 32'(busOut), 32'h25);
    checkOutput("wrReqFirst", 32'(wdataReq), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("wrDataWR", 32'(wr), 32'd0);
    checkOutput("wrDataBus", 32'(busOut), 32'h5A);
    repeat (6) @(negedge clk);
    checkOutput("wrDoneAt12", 32'({done, busy}), 32'b10);

    // Three-transfer read from 0x10
    rdTab[0] = 'h11; rdTab[1] = 'h22; rdTab[2] = 'h33;
    applyStimulus(1'b0, 'h10, 3, 0, 1'b0);
    busyCnt = 0; nGot = 0;
    for (int k = 0; k < 38; k++) begin
      if (busy === 1'b1) busyCnt++;
      if (rdataValid === 1'b1 && nGot < 4) begin
        got[nGot] = rdata;
        nGot++;
      end
      @(negedge clk);
    end
    checkOutput("rdBusyCycles", 32'(busyCnt), 32'd36);
    checkOutput("rdValidCount", 32'(nGot), 32'd3);
    checkOutput("rdData0", 32'(got[0]), 32'h11);
    checkOutput("rdData1", 32'(got[1]), 32'h22);
    checkOutput("rdData2", 32'(got[2]), 32'h33);

    // Address wrap at 0xFF, with and without auto-increment
    rdTab[0] = 'h3C; rdTab[1] = 'h4D;
    applyStimulus(1'b0, 'hFF, 2, 0, 1'b1);
    checkOutput("wrapFirst", 32'(busOut), 32'hFF);
    checkOutput("noIncFirst", 32'(busOutB), 32'hFF);
    repeat (12) @(negedge clk);
    checkOutput("wrapSecond", 32'(busOut), 32'h00);
    checkOutput("noIncSecond", 32'(busOutB), 32'hFF);
    checkOutput("noIncAddrPhase", 32'({aDB, csB, busOeB}), 32'b001);
    doneCnt = 0; doneCntB = 0; lastB = 0;
    for (int k = 0; k < 2 * P + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
      if (doneB === 1'b1) doneCntB++;
      if (rdataValidB === 1'b1) lastB = rdataB;
    end
    checkOutput("wrapDone", 32'(doneCnt), 32'd1);
    checkOutput("noIncDone", 32'(doneCntB), 32'd1);
    checkOutput("noIncRdata", 32'(lastB), 32'h4D);
    checkOutput("noIncIdle", 32'(busyB), 32'd0);

    // Start pulsed while a write burst is busy is ignored
    applyStimulus(1'b1, 'h30, 2, 'hC3, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b0; addr = 'h77; len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0;
    for (int k = 0; k < 2 * P + 4; k++) begin
      if (done === 1'b1) doneCnt++;
      @(negedge clk);
    end
    checkOutput("ignoredStartDone", 32'(doneCnt), 32'd1);

    // Abort during the write data phase
    applyStimulus(1'b1, 'h40, 1, 'h99, 1'b0);
    repeat (7) @(negedge clk);
    abort = 1'b1;
    mCut = cyc + 1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortStrobes", 32'({cs, wr, rd}), 32'b111);
    checkOutput("abortRelease", 32'({busOe, busy}), 32'b00);
    doneCnt = 0;
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("abortNoDone", 32'(doneCnt), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idleAbortBusy", 32'(busy), 32'd0);

    // Reset during a read data phase, then a fresh read
    rdTab[0] = 'hA1; rdTab[1] = 'hA2;
    applyStimulus(1'b0, 'h50, 2, 0, 1'b0);
    repeat (7) @(negedge clk);
    checkOutput("preResetRD", 32'(rd), 32'd0);
    #2;
    reset = 1'b0;
    mValid = 1'b0;
    #1;
    checkOutput("asyncRstStrobes", 32'({cs, rd}), 32'b11);
    checkOutput("asyncRstRelease", 32'({busOe, busy}), 32'b00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rdTab[0] = 'h6C;
    applyStimulus(1'b0, 'h60, 1, 0, 1'b0);
    waitDone(P + 4);
    checkOutput("postResetRdata", 32'(rdata), 32'h6C);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
